// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transfer sequencer.
//   state_t    : sequencer FSM states (IDLE, SETUP, XFER, HOLD, GAP)
//   MAX_BITS   : longest supported word
//   LEN_W      : width of the bit_len field
//   clamp_len(): maps a raw bit_len onto the usable range 1..MAX_BITS
package spi_pkg;

    localparam int MAX_BITS = 32;
    localparam int LEN_W    = 6;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        XFER  = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    // A length of 0, or anything beyond MAX_BITS, means a full-width word.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        logic [LEN_W-1:0] res;
        if ((len == 6'd0) || (len > LEN_W'(MAX_BITS))) begin
            res = LEN_W'(MAX_BITS);
        end else begin
            res = len;
        end
        return res;
    endfunction

endpackage

// File: rtl/spi_sclk_edge_gen.sv
// SCLK generator for the SPI sequencer.
// While en is high a half-period counter runs; every HALF_DIV clk cycles it
// raises tick. On a tick SCLK toggles unless park is high, in which case the
// tick only marks time and SCLK stays at its idle level.
// lead/trail are combinational and high in the cycle whose closing clk edge
// toggles SCLK, so the caller can act on exactly that edge.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   en         : run the half-period counter (SCLK parked at cpol when low)
//   park       : count the half period but suppress the toggle
//   cpol       : SCLK idle level
//   sclk       : registered SCLK
//   tick       : end of a half period
//   lead/trail : this tick toggles SCLK away from / back to cpol
module spi_sclk_edge_gen #(
    parameter int HALF_DIV = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic park,
    input  logic cpol,
    output logic sclk,
    output logic tick,
    output logic lead,
    output logic trail
);

    localparam int HCW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [HCW-1:0] HC_LAST = HCW'(HALF_DIV - 1);

    logic [HCW-1:0] hcnt_r;
    logic           sclk_r;

    // Half-period end and edge classification from current SCLK level.
    always_comb begin
        tick  = en && (hcnt_r == HC_LAST);
        lead  = tick && !park && (sclk_r == cpol);
        trail = tick && !park && (sclk_r != cpol);
    end

    // Half-period counter; restarts whenever the generator is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_r <= '0;
        end else if (!en || tick) begin
            hcnt_r <= '0;
        end else begin
            hcnt_r <= hcnt_r + HCW'(1);
        end
    end

    // SCLK register: idle level when disabled, toggles on unparked ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_r <= 1'b0;
        end else if (!en) begin
            sclk_r <= cpol;
        end else if (tick && !park) begin
            sclk_r <= ~sclk_r;
        end else begin
            sclk_r <= sclk_r;
        end
    end

    assign sclk = sclk_r;

endmodule

// File: rtl/spi_xfer_sequencer.sv
// SPI master single-word transfer sequencer.
// Accepts a request in IDLE, drops CS_n, waits CS_SETUP cycles, runs 2N SCLK
// half-periods plus one resting half-period, holds CS_n for CS_HOLD cycles,
// then raises CS_n with a done pulse and the received word, and keeps busy
// high for a further CS_IDLE cycles.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   start             : request, level-sampled in IDLE
//   cpol, cpha        : SPI mode, latched at accept
//   bit_len           : word length (0 or >32 means 32), latched at accept
//   tx_data           : word to send, right-aligned, MSB first
//   busy              : accept through end of the CS idle gap
//   done              : one-cycle completion pulse
//   rx_data           : received word, right-aligned, zero-extended
//   SCLK, MOSI, CS_n  : registered SPI pins
//   MISO              : SPI data in
module spi_xfer_sequencer
    import spi_pkg::*;
#(
    parameter int HALF_DIV = 25,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                cpol,
    input  logic                cpha,
    input  logic [LEN_W-1:0]    bit_len,
    input  logic [MAX_BITS-1:0] tx_data,
    output logic                busy,
    output logic                done,
    output logic [MAX_BITS-1:0] rx_data,
    output logic                SCLK,
    output logic                MOSI,
    input  logic                MISO,
    output logic                CS_n
);

    localparam int PH_MAX = (CS_SETUP > CS_HOLD) ?
                            ((CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE) :
                            ((CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE);
    localparam int PCW = $clog2(PH_MAX + 1);
    localparam logic [PCW-1:0] SETUP_LAST = PCW'(CS_SETUP - 1);
    localparam logic [PCW-1:0] HOLD_LAST  = PCW'(CS_HOLD - 1);
    localparam logic [PCW-1:0] IDLE_LAST  = PCW'(CS_IDLE - 1);

    state_t                state_r, state_nxt;
    logic [PCW-1:0]        ph_cnt_r;
    logic [6:0]            edge_cnt_r;
    logic                  cpol_r, cpha_r;
    logic [LEN_W-1:0]      len_r;
    logic [MAX_BITS-1:0]   tx_sh_r, rx_sh_r, rx_data_r;
    logic                  mosi_r, cs_n_r, busy_r, done_r;

    logic                  accept_s, ph_last_s, hold_end_s, gap_end_s;
    logic                  tick_s, lead_s, trail_s, park_s, last_trail_s;
    logic                  adv_s, sample_s, gen_en_s, gen_cpol_s, sclk_s;
    logic [LEN_W-1:0]      len_acc_s;
    logic [6:0]            align_s, two_n_s;
    logic [MAX_BITS-1:0]   tx_align_s;

    // Request decode and left-alignment of the outgoing word at accept.
    always_comb begin
        accept_s   = (state_r == IDLE) && start;
        len_acc_s  = clamp_len(bit_len);
        align_s    = 7'(MAX_BITS) - {1'b0, len_acc_s};
        tx_align_s = tx_data << align_s;
    end

    // End-of-phase detection for the fixed-length CS phases.
    always_comb begin
        ph_last_s = 1'b0;
        case (state_r)
            SETUP:   ph_last_s = (ph_cnt_r == SETUP_LAST);
            HOLD:    ph_last_s = (ph_cnt_r == HOLD_LAST);
            GAP:     ph_last_s = (ph_cnt_r == IDLE_LAST);
            default: ph_last_s = 1'b0;
        endcase
        hold_end_s = (state_r == HOLD) && ph_last_s;
        gap_end_s  = (state_r == GAP) && ph_last_s;
    end

    // Edge bookkeeping: after 2N toggles the next tick is the resting half.
    always_comb begin
        two_n_s      = {len_r, 1'b0};
        park_s       = (edge_cnt_r == two_n_s);
        last_trail_s = (edge_cnt_r == (two_n_s - 7'd1));
        gen_en_s     = (state_r == XFER);
        gen_cpol_s   = (state_r == IDLE) ? cpol : cpol_r;
        adv_s        = cpha_r ? lead_s : (trail_s && !last_trail_s);
        sample_s     = cpha_r ? trail_s : lead_s;
    end

    spi_sclk_edge_gen #(
        .HALF_DIV (HALF_DIV)
    ) u_sclk_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (gen_en_s),
        .park  (park_s),
        .cpol  (gen_cpol_s),
        .sclk  (sclk_s),
        .tick  (tick_s),
        .lead  (lead_s),
        .trail (trail_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_nxt = SETUP;
                else       state_nxt = IDLE;
            end
            SETUP: begin
                if (ph_last_s) state_nxt = XFER;
                else           state_nxt = SETUP;
            end
            XFER: begin
                if (tick_s && park_s) state_nxt = HOLD;
                else                  state_nxt = XFER;
            end
            HOLD: begin
                if (ph_last_s) state_nxt = GAP;
                else           state_nxt = HOLD;
            end
            GAP: begin
                if (ph_last_s) state_nxt = IDLE;
                else           state_nxt = GAP;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Phase counter for SETUP/HOLD/GAP, cleared on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_cnt_r <= '0;
        end else if (state_nxt != state_r) begin
            ph_cnt_r <= '0;
        end else if ((state_r == SETUP) || (state_r == HOLD) || (state_r == GAP)) begin
            ph_cnt_r <= ph_cnt_r + PCW'(1);
        end else begin
            ph_cnt_r <= '0;
        end
    end

    // Half-period tick counter across XFER (2N toggles plus the resting half).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt_r <= 7'd0;
        end else if (state_r != XFER) begin
            edge_cnt_r <= 7'd0;
        end else if (tick_s) begin
            edge_cnt_r <= edge_cnt_r + 7'd1;
        end else begin
            edge_cnt_r <= edge_cnt_r;
        end
    end

    // Transfer configuration captured at accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpol_r <= 1'b0;
            cpha_r <= 1'b0;
            len_r  <= '0;
        end else if (accept_s) begin
            cpol_r <= cpol;
            cpha_r <= cpha;
            len_r  <= len_acc_s;
        end else begin
            cpol_r <= cpol_r;
            cpha_r <= cpha_r;
            len_r  <= len_r;
        end
    end

    // Transmit shifter. MOSI shows bit N-1 from CS_n fall; with CPHA=0 the
    // next bit sits one below the MSB, with CPHA=1 the first leading edge
    // re-presents the MSB before shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sh_r <= '0;
            mosi_r  <= 1'b0;
        end else if (accept_s) begin
            tx_sh_r <= tx_align_s;
            mosi_r  <= tx_align_s[MAX_BITS-1];
        end else if (adv_s) begin
            tx_sh_r <= tx_sh_r << 1;
            mosi_r  <= cpha_r ? tx_sh_r[MAX_BITS-1] : tx_sh_r[MAX_BITS-2];
        end else begin
            tx_sh_r <= tx_sh_r;
            mosi_r  <= mosi_r;
        end
    end

    // Receive shifter: LSB-in, so after N samples the first bit sits at N-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sh_r <= '0;
        end else if (accept_s) begin
            rx_sh_r <= '0;
        end else if (sample_s) begin
            rx_sh_r <= {rx_sh_r[MAX_BITS-2:0], MISO};
        end else begin
            rx_sh_r <= rx_sh_r;
        end
    end

    // Chip select, busy, done and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_n_r    <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            rx_data_r <= '0;
        end else begin
            done_r <= hold_end_s;
            if (accept_s) begin
                cs_n_r <= 1'b0;
            end else if (hold_end_s) begin
                cs_n_r <= 1'b1;
            end else begin
                cs_n_r <= cs_n_r;
            end
            if (accept_s) begin
                busy_r <= 1'b1;
            end else if (gap_end_s) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= busy_r;
            end
            if (hold_end_s) begin
                rx_data_r <= rx_sh_r;
            end else begin
                rx_data_r <= rx_data_r;
            end
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign rx_data = rx_data_r;
    assign SCLK    = sclk_s;
    assign MOSI    = mosi_r;
    assign CS_n    = cs_n_r;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Self-checking bench for spi_xfer_sequencer. A slave-side model watches the
// SPI pins: it counts SCLK toggles, captures MOSI and presents the next MISO
// bit at each sampling edge, and derives expected latency, toggle count and
// received word from the transfer parameters.
module tb_spi_xfer_sequencer;

    localparam int HD  = 2;
    localparam int CSS = 2;
    localparam int CSH = 2;
    localparam int CSI = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        cpol = 1'b0;
    logic        cpha = 1'b0;
    logic [5:0]  bit_len = 6'd0;
    logic [31:0] tx_data = 32'd0;
    logic        busy, done, sclk, mosi, cs_n, miso;
    logic [31:0] rx_data;
    logic        loop_en = 1'b0;
    logic        miso_v = 1'b0;
    logic [31:0] prev_rx = 32'd0;

    int err_cnt = 0;
    int chk_cnt = 0;

    assign miso = loop_en ? mosi : miso_v;

    always #5 clk = ~clk;

    spi_xfer_sequencer #(
        .HALF_DIV (HD),
        .CS_SETUP (CSS),
        .CS_HOLD  (CSH),
        .CS_IDLE  (CSI)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .cpol    (cpol),
        .cpha    (cpha),
        .bit_len (bit_len),
        .tx_data (tx_data),
        .busy    (busy),
        .done    (done),
        .rx_data (rx_data),
        .SCLK    (sclk),
        .MOSI    (mosi),
        .MISO    (miso),
        .CS_n    (cs_n)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Follows one transfer, starting at the negedge just after its accept edge.
    task automatic track(input logic cp, input logic ch, input int n,
                         input logic [31:0] tx, input logic [31:0] mw,
                         input int pulse_at, input bit hold, input int rst_at);
        int          toggles = 0;
        int          lat = -1;
        int          bitidx = n - 1;
        int          cs_early = 0;
        int          k;
        logic        prev;
        logic        leading;
        logic [31:0] cap = 32'd0;
        logic [31:0] mask;
        logic [31:0] t;
        logic [31:0] exp_rx;
        mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        exp_rx = loop_en ? (tx & mask) : (mw & mask);
        t = tx >> (n - 1);
        check_eq("cs_fall", cs_n, 0);
        check_eq("busy_set", busy, 1);
        check_eq("mosi_first", mosi, t[0]);
        check_eq("sclk_idle_pre", sclk, cp);
        check_eq("rx_hold", rx_data, prev_rx);
        t = mw >> (n - 1);
        miso_v = t[0];
        if (!hold) begin
            start   = 1'b0;
            cpol    = 1'($urandom_range(0, 1));
            cpha    = 1'($urandom_range(0, 1));
            bit_len = 6'($urandom_range(0, 63));
            tx_data = $urandom;
        end
        prev = sclk;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            if (cyc == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_eq("rst_cs", cs_n, 1);
                check_eq("rst_busy", busy, 0);
                check_eq("rst_sclk", sclk, 0);
                check_eq("rst_rx", rx_data, 0);
                for (int r = 0; r < 4; r++) begin
                    @(negedge clk);
                    check_eq("rst_no_done", done, 0);
                end
                rst_n = 1'b1;
                prev_rx = 32'd0;
                @(negedge clk);
                return;
            end
            if (cyc == pulse_at) start = 1'b1;
            else if ((pulse_at > 0) && (cyc == pulse_at + 1)) start = 1'b0;
            if (sclk !== prev) begin
                toggles++;
                leading = (prev == cp);
                if (ch ? !leading : leading) begin
                    cap = {cap[30:0], mosi};
                    bitidx--;
                    if (bitidx >= 0) begin
                        t = mw >> bitidx;
                        miso_v = t[0];
                    end
                end
            end
            prev = sclk;
            if (done) begin
                lat = cyc;
                break;
            end
            if (cs_n) cs_early++;
        end
        check_eq("latency", lat, CSS + (2 * n + 1) * HD + CSH);
        check_eq("toggles", toggles, 2 * n);
        check_eq("rx_data", rx_data, exp_rx);
        check_eq("mosi_bits", cap, tx & mask);
        check_eq("sclk_idle_post", sclk, cp);
        check_eq("cs_rise", cs_n, 1);
        check_eq("cs_early", cs_early, 0);
        prev_rx = exp_rx;
        @(negedge clk);
        check_eq("done_pulse", done, 0);
        check_eq("busy_in_gap", busy, 1);
        k = 1;
        if (hold) begin
            while (cs_n && (k < 20)) begin
                @(negedge clk);
                k++;
            end
            check_eq("restart_gap", k, CSI + 1);
        end else begin
            while (busy && (k < 20)) begin
                @(negedge clk);
                k++;
            end
            check_eq("busy_gap", k, CSI);
            if (pulse_at > 0) begin
                repeat (3) @(negedge clk);
                check_eq("pulse_ignored", cs_n, 1);
            end
        end
    endtask

    // Waits for idle, requests a transfer and follows it.
    task automatic run_xfer(input logic cp, input logic ch, input logic [5:0] bl,
                            input logic [31:0] tx, input logic [31:0] mw, input logic lp,
                            input int pulse_at, input bit hold, input int rst_at);
        int n;
        int w = 0;
        while ((busy || !rst_n) && (w < 300)) begin
            @(negedge clk);
            w++;
        end
        check_eq("idle_wait", busy, 0);
        n = ((bl == 6'd0) || (bl > 6'd32)) ? 32 : int'(bl);
        cpol    = cp;
        cpha    = ch;
        bit_len = bl;
        tx_data = tx;
        loop_en = lp;
        start   = 1'b1;
        @(negedge clk);
        track(cp, ch, n, tx, mw, pulse_at, hold, rst_at);
        if (hold) begin
            track(cp, ch, n, tx, mw, 0, 1'b0, 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_cs", cs_n, 1);
        check_eq("reset_sclk", sclk, 0);
        check_eq("reset_mosi", mosi, 0);
        check_eq("reset_rx", rx_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Mode 0, loopback
        run_xfer(1'b0, 1'b0, 6'd8, 32'h0000_00A5, 32'd0, 1'b1, 0, 1'b0, 0);
        // Mode 3, MISO high
        run_xfer(1'b1, 1'b1, 6'd16, 32'h0000_1234, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, 0);
        // Mode 1, single bit, MISO low
        run_xfer(1'b0, 1'b1, 6'd1, 32'h0000_0001, 32'd0, 1'b0, 0, 1'b0, 0);
        // bit_len 0 means a full 32-bit word
        run_xfer(1'b0, 1'b0, 6'd0, 32'hC3A5_0F96, 32'h5A3C_E187, 1'b0, 0, 1'b0, 0);
        // MSB set: MOSI high from CS_n fall
        run_xfer(1'b0, 1'b0, 6'd8, 32'h0000_0080, 32'h0000_0033, 1'b0, 0, 1'b0, 0);
        // start pulse during XFER is ignored
        run_xfer(1'b0, 1'b0, 6'd8, 32'h0000_005C, 32'h0000_00E1, 1'b0, 10, 1'b0, 0);
        // start held high: back-to-back transfers
        run_xfer(1'b1, 1'b0, 6'd4, 32'h0000_000B, 32'h0000_0006, 1'b0, 0, 1'b1, 0);
        // reset mid-XFER, then a fresh transfer
        run_xfer(1'b1, 1'b1, 6'd16, 32'h0000_BEEF, 32'h0000_1357, 1'b0, 0, 1'b0, 15);
        run_xfer(1'b0, 1'b1, 6'd12, 32'h0000_0ABC, 32'h0000_0F0F, 1'b0, 0, 1'b0, 0);
        // randomized transfers, including out-of-range lengths
        for (int i = 0; i < 8; i++) begin
            run_xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     6'($urandom_range(0, 63)), $urandom, $urandom,
                     1'($urandom_range(0, 1)), 0, 1'b0, 0);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
